// File: rtl/pcm_frame_packer.sv
// Packs PCM samples into little-endian bytes for the TX FIFO, with a sync/sequence
// header every SAMPLES_PER_FRAME samples and overrun accounting on a one-deep hold.
module pcm_frame_packer #(
   parameter int          DATA_SIZE         = 24,
   parameter int          SAMPLES_PER_FRAME = 32,
   parameter logic [15:0] SYNC_WORD         = 16'hA55A
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic                 sample_valid_i,
   input  logic [DATA_SIZE-1:0] sample_data_i,
   input  logic                 fifo_full_i,
   output logic                 fifo_wr_en_o,
   output logic [7:0]           fifo_write_data_o,
   output logic                 overrun_o,
   output logic [15:0]          drop_count_o,
   output logic [7:0]           seq_o
);
   localparam int BYTES = DATA_SIZE / 8;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int SW    = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;

   typedef enum logic [2:0] {IDLE, HDR_SYNC_HI, HDR_SYNC_LO, HDR_SEQ, DATA, GAP} state_t;

   state_t                 state, ret;
   logic [BYTES-1:0][7:0]  hold;
   logic                   hold_full;
   logic [BW-1:0]          byte_idx;
   logic [SW-1:0]          sample_idx;
   logic                   last_byte, accept, take;

   // The hold slot is released on the edge that issues its last byte, so a
   // sample arriving on that same edge is taken instead of dropped.
   assign last_byte = (state == DATA) && !fifo_full_i && (byte_idx == BW'(BYTES-1));
   assign accept    = sample_valid_i && enable_i;
   assign take      = accept && (!hold_full || last_byte);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         ret               <= IDLE;
         hold              <= '0;
         hold_full         <= 1'b0;
         byte_idx          <= '0;
         sample_idx        <= '0;
         fifo_wr_en_o      <= 1'b0;
         fifo_write_data_o <= 8'h00;
         overrun_o         <= 1'b0;
         drop_count_o      <= 16'h0000;
         seq_o             <= 8'h00;
      end else begin
         fifo_wr_en_o <= 1'b0;

         if (take) begin
            hold      <= sample_data_i;
            hold_full <= 1'b1;
         end else if (last_byte) begin
            hold_full <= 1'b0;
         end

         if (accept && hold_full && !last_byte) begin
            overrun_o <= 1'b1;
            if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
         end

         case (state)
            IDLE: begin
               if (hold_full) begin
                  if (sample_idx == '0) begin
                     state <= HDR_SYNC_HI;
                  end else begin
                     byte_idx <= '0;
                     state    <= DATA;
                  end
               end else if (!enable_i) begin
                  // stream paused: restart framing so the next sample gets a header
                  sample_idx <= '0;
               end
            end
            HDR_SYNC_HI: if (!fifo_full_i) begin
               fifo_wr_en_o      <= 1'b1;
               fifo_write_data_o <= SYNC_WORD[15:8];
               ret               <= HDR_SYNC_LO;
               state             <= GAP;
            end
            HDR_SYNC_LO: if (!fifo_full_i) begin
               fifo_wr_en_o      <= 1'b1;
               fifo_write_data_o <= SYNC_WORD[7:0];
               ret               <= HDR_SEQ;
               state             <= GAP;
            end
            HDR_SEQ: if (!fifo_full_i) begin
               fifo_wr_en_o      <= 1'b1;
               fifo_write_data_o <= seq_o;
               seq_o             <= seq_o + 8'd1;
               byte_idx          <= '0;
               ret               <= DATA;
               state             <= GAP;
            end
            DATA: if (!fifo_full_i) begin
               fifo_wr_en_o      <= 1'b1;
               fifo_write_data_o <= hold[byte_idx];
               state             <= GAP;
               if (byte_idx == BW'(BYTES-1)) begin
                  ret        <= IDLE;
                  sample_idx <= (sample_idx == SW'(SAMPLES_PER_FRAME-1)) ? '0 : sample_idx + 1'b1;
               end else begin
                  ret      <= DATA;
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            GAP:     state <= ret;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
